mem_arbiter: RTL

- Two-master to one-slave AXI4-Lite arbiter between the CPU core and the single memory slave.
- Master 0 is the instruction fetch unit, which only reads. Master 1 is the load/store unit, which reads and writes.
- One transaction is in flight at a time. The granted master's channels pass straight through to the slave; the other master is stalled.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-master memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_id_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selector; MEM_ARB_RR_EN switches fixed priority to round-robin
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_rd_req,
    input  logic       lsu_wr_req,
    input  grant_id_e  last_grant,
    output arb_state_e next_state
);

    logic ifu_turn;

`ifdef MEM_ARB_RR_EN
    logic lsu_req;
    assign lsu_req  = lsu_rd_req | lsu_wr_req;
    // IFU only overrides the LSU on contention when the LSU had the previous grant
    assign ifu_turn = ifu_req & lsu_req & (last_grant == GNT_LSU);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign ifu_turn          = 1'b0;
`endif

    always_comb begin
        next_state = IDLE;
        if (ifu_turn) begin
            next_state = IF_RD;
        end else if (lsu_wr_req) begin
            next_state = LS_WR;
        end else if (lsu_rd_req) begin
            next_state = LS_RD;
        end else if (ifu_req) begin
            next_state = IF_RD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master AXI4-Lite arbiter, one transaction in flight; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    arb_state_e state_q, state_d, pick_state;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       wr_both_done;
    grant_id_e  last_grant;

    assign wr_both_done = aw_done_q & w_done_q;

    mem_arb_pick u_pick (
        .ifu_req    (ifu_arvalid),
        .lsu_rd_req (lsu_arvalid),
        .lsu_wr_req (lsu_awvalid | lsu_wvalid),
        .last_grant (last_grant),
        .next_state (pick_state)
    );

`ifdef MEM_ARB_RR_EN
    grant_id_e last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && pick_state != IDLE) begin
            last_grant_d = (pick_state == IF_RD) ? GNT_IFU : GNT_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = GNT_LSU;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: state_d = pick_state;
            IF_RD, LS_RD: begin
                if (mem_rvalid & mem_rready) begin
                    state_d = IDLE;
                end
            end
            LS_WR: begin
                if (mem_awvalid & mem_awready) aw_done_d = 1'b1;
                if (mem_wvalid & mem_wready)   w_done_d  = 1'b1;
                if (mem_bvalid & mem_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pure pass-through of the granted master; everything else is held at zero
    always_comb begin
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = RESP_OKAY;
        lsu_bvalid  = 1'b0;
        case (state_q)
            IF_RD: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
            end
            LS_RD: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
            end
            LS_WR: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done_q;
                lsu_wready  = mem_wready & ~w_done_q;
                // the response is only meaningful once both address and data were accepted
                lsu_bvalid  = mem_bvalid & wr_both_done;
                mem_bready  = lsu_bready & wr_both_done;
                lsu_bresp   = wr_both_done ? mem_bresp : RESP_OKAY;
            end
            default: ;
        endcase
    end

endmodule
